// File: rtl/proc_imuldiv_iter_if.sv
// Request/response handshake bundle for the iterative multiply/divide unit.
// The master side issues requests and consumes results; the slave side is the unit.
interface proc_imuldiv_iter_if #(
  parameter int p_nbits = 32
);
  logic               istream_val;
  logic               istream_rdy;
  logic [2:0]         istream_msg_op;
  logic [p_nbits-1:0] istream_msg_a;
  logic [p_nbits-1:0] istream_msg_b;
  logic               ostream_val;
  logic               ostream_rdy;
  logic [p_nbits-1:0] ostream_msg;

  modport master (
    output istream_val, istream_msg_op, istream_msg_a, istream_msg_b, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg
  );

  modport slave (
    input  istream_val, istream_msg_op, istream_msg_a, istream_msg_b, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg
  );
endinterface

// File: rtl/proc_imuldiv_iter.sv
// Iterative MUL/MULH/MULHU/DIV/DIVU/REM/REMU unit, one bit per cycle, val/rdy on both sides.
// Optional macro PROC_IMULDIV_EARLY_TERM_EN ends a multiply once the remaining multiplier bits are zero.
module proc_imuldiv_iter #(
  parameter  int p_nbits    = 32,
  localparam int p_cnt_bits = $clog2(p_nbits) + 1
) (
  input  logic               clk,
  input  logic               reset,
  proc_imuldiv_iter_if.slave io
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  localparam logic [p_cnt_bits-1:0] CNT_LAST = p_cnt_bits'(p_nbits - 1);

  state_t                 state;
  logic [p_cnt_bits-1:0]  cnt;
  logic [2:0]             op;
  logic                   neg;
  logic [2*p_nbits-1:0]   acc;
  logic [2*p_nbits-1:0]   mcand;
  logic [p_nbits-1:0]     mplier;
  logic [p_nbits:0]       rem;
  logic                   res_val;
  logic [p_nbits-1:0]     res_msg;

  logic                   accept;
  logic                   sgn_op;
  logic                   sa;
  logic                   sb;
  logic                   neg_in;
  logic [p_nbits-1:0]     a_abs;
  logic [p_nbits-1:0]     b_abs;

  logic                   is_mul;
  logic                   ge;
  logic                   last;
  logic [p_nbits+1:0]     shifted;
  logic [p_nbits+1:0]     diff;
  logic [2*p_nbits-1:0]   acc_nx;
  logic [2*p_nbits-1:0]   mcand_nx;
  logic [p_nbits-1:0]     mplier_nx;
  logic [p_nbits:0]       rem_nx;

  // Sign/magnitude fix-up of the unsigned core result for the selected op.
  function automatic logic [p_nbits-1:0] result_of(
    input logic [2:0]           f_op,
    input logic                 f_neg,
    input logic [2*p_nbits-1:0] f_prod,
    input logic [p_nbits-1:0]   f_quo,
    input logic [p_nbits-1:0]   f_rem
  );
    logic [2*p_nbits-1:0] p;
    p = f_neg ? -f_prod : f_prod;
    case (f_op)
      3'd1, 3'd2: return p[2*p_nbits-1:p_nbits];
      3'd3, 3'd4: return f_neg ? -f_quo : f_quo;
      3'd5, 3'd6: return f_neg ? -f_rem : f_rem;
      default:    return f_prod[p_nbits-1:0];
    endcase
  endfunction

  assign io.istream_rdy = reset & ((state == IDLE) | ((state == DONE) & io.ostream_rdy));
  assign accept         = io.istream_val & io.istream_rdy;

  assign sgn_op = (io.istream_msg_op == 3'd1) | (io.istream_msg_op == 3'd3) |
                  (io.istream_msg_op == 3'd5);
  assign sa     = sgn_op & io.istream_msg_a[p_nbits-1];
  assign sb     = sgn_op & io.istream_msg_b[p_nbits-1];
  assign a_abs  = sa ? -io.istream_msg_a : io.istream_msg_a;
  assign b_abs  = sb ? -io.istream_msg_b : io.istream_msg_b;

  // A zero divisor must yield an all-ones quotient, so the quotient is never negated then.
  always_comb begin
    case (io.istream_msg_op)
      3'd1:    neg_in = sa ^ sb;
      3'd3:    neg_in = (sa ^ sb) & (|io.istream_msg_b);
      3'd5:    neg_in = sa;
      default: neg_in = 1'b0;
    endcase
  end

  assign is_mul = (op == 3'd0) | (op == 3'd1) | (op == 3'd2) | (op == 3'd7);

  always_comb begin
    acc_nx    = acc;
    mcand_nx  = mcand;
    mplier_nx = mplier;
    rem_nx    = rem;
    shifted   = {rem, mcand[p_nbits-1]};
    diff      = shifted - {2'b00, mplier};
    ge        = ~diff[p_nbits+1];
    if (is_mul) begin
      if (mplier[0]) acc_nx = acc + mcand;
      mcand_nx  = mcand << 1;
      mplier_nx = mplier >> 1;
    end else begin
      rem_nx   = ge ? diff[p_nbits:0] : shifted[p_nbits:0];
      mcand_nx = {mcand[2*p_nbits-1:p_nbits], mcand[p_nbits-2:0], ge};
    end
  end

`ifdef PROC_IMULDIV_EARLY_TERM_EN
  assign last = (cnt == CNT_LAST) | (is_mul & (mplier_nx == '0));
`else
  assign last = (cnt == CNT_LAST);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op      <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      rem     <= '0;
      res_val <= 1'b0;
      res_msg <= '0;
    end else if (accept) begin
      state   <= CALC;
      cnt     <= '0;
      op      <= io.istream_msg_op;
      neg     <= neg_in;
      acc     <= '0;
      mcand   <= {{p_nbits{1'b0}}, a_abs};
      mplier  <= b_abs;
      rem     <= '0;
      res_val <= 1'b0;
    end else begin
      case (state)
        CALC: begin
          acc    <= acc_nx;
          mcand  <= mcand_nx;
          mplier <= mplier_nx;
          rem    <= rem_nx;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state   <= DONE;
            res_val <= 1'b1;
            res_msg <= result_of(op, neg, acc_nx, mcand_nx[p_nbits-1:0], rem_nx[p_nbits-1:0]);
          end
        end
        DONE: begin
          if (io.ostream_rdy) begin
            state   <= IDLE;
            res_val <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.ostream_val = res_val;
  assign io.ostream_msg = res_msg;

endmodule

// File: tb/tb_proc_imuldiv_iter.sv
// Scoreboard bench for proc_imuldiv_iter: 32-bit instance driven through a queue-based
// scoreboard plus an 8-bit instance for width parametrisation.
module tb_proc_imuldiv_iter;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  logic [31:0] want_q[$];
  int          t_q[$];
  string       nm_q[$];

  bit seen = 0;
  int start = 0;

  proc_imuldiv_iter_if #(.p_nbits(32)) io ();
  proc_imuldiv_iter_if #(.p_nbits(8))  io8 ();

  proc_imuldiv_iter #(.p_nbits(32)) dut (.clk(clk), .reset(reset), .io(io));
  proc_imuldiv_iter #(.p_nbits(8))  dut8 (.clk(clk), .reset(reset), .io(io8));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, want);
  endtask

  // Monitor: pops the scoreboard whenever a result transfers.
  initial begin
    forever begin
      @(negedge clk);
      if (io.ostream_val && !seen) begin
        seen  = 1;
        start = cyc;
      end
      if (io.ostream_val && io.ostream_rdy) begin
        if (want_q.size() == 0) begin
          check("unexpected_result", io.ostream_msg, 32'h0);
        end else begin
          automatic logic [31:0] w  = want_q.pop_front();
          automatic int          t  = t_q.pop_front();
          automatic string       nm = nm_q.pop_front();
          check(nm, io.ostream_msg, w);
`ifndef PROC_IMULDIV_EARLY_TERM_EN
          check({nm, "_latency"}, 32'(start - t), 32'd32);
`endif
        end
        seen = 0;
      end
    end
  end

  // Caller is between a posedge and the following negedge.
  task automatic issue(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] want);
    bit ok = 0;
    io.istream_msg_op = op;
    io.istream_msg_a  = a;
    io.istream_msg_b  = b;
    io.istream_val    = 1'b1;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (io.istream_rdy) ok = 1;
    end
    if (ok) begin
      want_q.push_back(want);
      t_q.push_back(cyc + 1);
      nm_q.push_back(nm);
    end else begin
      check({nm, "_accept"}, 32'(ok), 32'd1);
    end
    @(posedge clk);
    #1;
    io.istream_val    = 1'b0;
    io.istream_msg_op = 3'($urandom());
    io.istream_msg_a  = $urandom();
    io.istream_msg_b  = $urandom();
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && want_q.size() != 0; i++) @(negedge clk);
    check("drain", 32'(want_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run8(input string nm, input logic [2:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] want);
    bit ok = 0;
    int t0;
    io8.istream_msg_op = op;
    io8.istream_msg_a  = a;
    io8.istream_msg_b  = b;
    io8.istream_val    = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (io8.istream_rdy) ok = 1;
    end
    t0 = cyc + 1;
    @(posedge clk);
    #1;
    io8.istream_val = 1'b0;
    io8.istream_msg_a = 8'($urandom());
    io8.istream_msg_b = 8'($urandom());
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (io8.ostream_val) ok = 1;
    end
    check({nm, "_done"}, 32'(ok), 32'd1);
    check(nm, {24'h0, io8.ostream_msg}, {24'h0, want});
`ifndef PROC_IMULDIV_EARLY_TERM_EN
    check({nm, "_latency"}, 32'(cyc - t0), 32'd8);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int stale;
    reset = 1'b1;
    io.istream_val = 1'b0;  io.istream_msg_op = 3'd0;
    io.istream_msg_a = '0;  io.istream_msg_b = '0;  io.ostream_rdy = 1'b1;
    io8.istream_val = 1'b0; io8.istream_msg_op = 3'd0;
    io8.istream_msg_a = '0; io8.istream_msg_b = '0; io8.ostream_rdy = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("reset_ostream_val", 32'(io.ostream_val), 32'd0);
    check("reset_istream_rdy", 32'(io.istream_rdy), 32'd0);
    check("reset_ostream_msg", io.ostream_msg, 32'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1 check("idle_istream_rdy", 32'(io.istream_rdy), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back directed vectors.
    issue("mul",        3'd0, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
    issue("mulh",       3'd1, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFFF);
    issue("mulhu",      3'd2, 32'd7,          32'hFFFFFFFD, 32'h00000006);
    issue("div",        3'd3, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFA);
    issue("rem",        3'd5, 32'hFFFFFFEC,   32'd3,        32'hFFFFFFFE);
    issue("divu",       3'd4, 32'd20,         32'd3,        32'd6);
    issue("remu",       3'd6, 32'd20,         32'd3,        32'd2);
    issue("divu_by0",   3'd4, 32'd5,          32'd0,        32'hFFFFFFFF);
    issue("remu_by0",   3'd6, 32'd5,          32'd0,        32'd5);
    issue("div_by0",    3'd3, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFFF);
    issue("rem_by0",    3'd5, 32'hFFFFFFF9,   32'd0,        32'hFFFFFFF9);
    issue("div_ovf",    3'd3, 32'h80000000,   32'hFFFFFFFF, 32'h80000000);
    issue("rem_ovf",    3'd5, 32'h80000000,   32'hFFFFFFFF, 32'h00000000);
    issue("op7_mul",    3'd7, 32'd7,          32'hFFFFFFFD, 32'hFFFFFFEB);
    issue("mulh_min",   3'd1, 32'h80000000,   32'h80000000, 32'h40000000);
    issue("mulhu_max",  3'd2, 32'hFFFFFFFF,   32'hFFFFFFFF, 32'hFFFFFFFE);
    issue("div_negb",   3'd3, 32'd7,          32'hFFFFFFFE, 32'hFFFFFFFD);
    issue("rem_negb",   3'd5, 32'd7,          32'hFFFFFFFE, 32'h00000001);
    drain();

    // Back-pressure in DONE, then release together with a new request.
    io.ostream_rdy = 1'b0;
    issue("bp_mul", 3'd0, 32'h1234, 32'h10, 32'h00012340);
    begin
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (io.ostream_val) ok = 1;
      end
      check("bp_reach_done", 32'(ok), 32'd1);
    end
    repeat (10) begin
      @(negedge clk);
      check("bp_val_held", 32'(io.ostream_val), 32'd1);
      check("bp_msg_stable", io.ostream_msg, 32'h00012340);
      check("bp_istream_rdy", 32'(io.istream_rdy), 32'd0);
    end
    @(posedge clk);
    #1;
    io.ostream_rdy = 1'b1;
    issue("bp_next_divu", 3'd4, 32'd100, 32'd7, 32'd14);
    drain();

    // Asynchronous reset in the middle of a divide.
    issue("abort_divu", 3'd4, 32'd1000, 32'd7, 32'd142);
    repeat (15) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_ostream_val", 32'(io.ostream_val), 32'd0);
    check("abort_istream_rdy", 32'(io.istream_rdy), 32'd0);
    check("abort_ostream_msg", io.ostream_msg, 32'd0);
    void'(want_q.pop_back());
    void'(t_q.pop_back());
    void'(nm_q.pop_back());
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("post_reset_istream_rdy", 32'(io.istream_rdy), 32'd1);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (io.ostream_val) stale++;
    end
    check("no_stale_result", 32'(stale), 32'd0);
    @(posedge clk);
    #1;
    issue("post_reset_mul", 3'd0, 32'd3, 32'd5, 32'd15);
    drain();

    // Narrow instance.
    run8("w8_mul",  3'd0, 8'h0F, 8'h11, 8'hFF);
    run8("w8_div_ovf", 3'd3, 8'h80, 8'hFF, 8'h80);
    run8("w8_mulh", 3'd1, 8'hF0, 8'h03, 8'hFF);
    run8("w8_rem",  3'd5, 8'hF9, 8'h02, 8'hFF);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/proc_imuldiv_iter.md
Name: proc_imuldiv_iter

Overview:
- Iterative, parametrised integer multiply/divide unit for the X stage of the pipelined processor. It is the successor of the fixed 32-bit multiplier.
- Generalised in operand width; adds a selectable mode covering MUL, MULH, MULHU, DIV, DIVU, REM and REMU.
- Uses a val/rdy handshake on both sides, so the control unit stalls D/X on `istream_rdy` and stalls M on `ostream_val`.

Parameters:
- p_nbits, 32, operand and result width; any value of 4 or more.
- p_cnt_bits, $clog2(p_nbits)+1, iteration counter width (derived; not overridden).

Ports:
- clk, input, 1, clock.
- reset, input, 1, one clock; reset is asynchronous and active-low.
- istream_val, input, 1, request valid.
- istream_rdy, output, 1, unit can accept a request.
- istream_msg_op, input, 3, 0=MUL 1=MULH 2=MULHU 3=DIV 4=DIVU 5=REM 6=REMU 7=reserved (treated as MUL).
- istream_msg_a, input, p_nbits, operand a (rs1).
- istream_msg_b, input, p_nbits, operand b (rs2).
- ostream_val, output, 1, result valid.
- ostream_rdy, input, 1, consumer accepts the result.
- ostream_msg, output, p_nbits, result.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0, all datapath registers=0, ostream_val=0, ostream_msg=0, istream_rdy=0 while reset is held. Reset mid-operation aborts the operation and no result is ever produced for it.
- FSM states: IDLE, CALC, DONE.
  - IDLE: istream_rdy=1. On istream_val, latch op; latch |a|, |b| for signed ops (raw values for unsigned ops); latch sign flags; clear accumulator and remainder; counter=0; go to CALC.
  - CALC: one iteration per cycle, counter increments. When counter==p_nbits-1, go to DONE on the next edge.
  - DONE: ostream_val=1 and ostream_msg is held stable. If ostream_rdy, the result transfers.
- Throughput: istream_rdy = IDLE | (DONE & ostream_rdy).
  - A request accepted in DONE goes straight to CALC. This gives back-to-back operation with no bubble.
  - If there is no new request in DONE, ostream_rdy moves the FSM to IDLE.
- Latency: handshake at edge t gives ostream_val=1 in the cycle after edge t+p_nbits, i.e. p_nbits+1 cycles.
- Multiply: shift-add on a 2*p_nbits unsigned accumulator, one multiplier bit per iteration (LSB first).
  - MUL returns the low p_nbits bits.
  - MULH negates the 2N product if sign(a)^sign(b), then returns the high p_nbits bits.
  - MULHU returns the high bits unsigned.
- Divide: restoring division, one quotient bit per iteration (MSB first), on a p_nbits+1 partial remainder.
  - Quotient sign = sign(a)^sign(b).
  - Remainder sign = sign(a).
- Divide-by-zero (b==0), full latency still taken:
  - DIV/DIVU return all ones.
  - REM/REMU return a unmodified.
- Signed overflow (a = most negative, b = -1): DIV returns a, REM returns 0.
- Op 7 behaves exactly as MUL.
- Inputs are sampled only on the handshake edge. Operand changes at any other time are ignored.
- istream_val with istream_rdy=0: no effect; the requester holds its request.

Optional Feature:
- Macro: PROC_IMULDIV_EARLY_TERM_EN.
- Defined: in CALC, a multiply whose remaining multiplier bits are all zero goes to DONE on the next edge, skipping the remaining iterations.
  - Minimum multiply latency is 2 cycles (e.g. b=0 or b=1).
  - Divide latency is unchanged.
  - Results are bit-identical to the feature-off build.
- Undefined: fixed p_nbits+1 latency for all ops.
- Benches check latency only in fixed mode. Values are checked in both builds.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), p_nbits=32 -> ostream_msg=0xFFFFFFEB exactly 33 cycles after handshake. MULH same operands -> 0xFFFFFFFF; MULHU -> 0x00000006.
- DIV a=-20, b=3 -> 0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2). DIVU a=20, b=3 -> 6; REMU -> 2.
- Corner cases:
  - DIVU a=5, b=0 -> 0xFFFFFFFF; REMU -> 5.
  - DIV a=0x80000000, b=-1 -> 0x80000000; REM -> 0.
- Back-pressure: hold ostream_rdy=0 for 10 cycles in DONE -> ostream_val stays 1, ostream_msg stable, istream_rdy=0. Then ostream_rdy=1 together with a new istream_val -> accepted in the same cycle, next result 33 cycles later.
- Reset: assert reset in CALC iteration 15 -> ostream_val=0 and istream_rdy=0 immediately (asynchronous). After release, state is IDLE and istream_rdy=1. No stale result appears.
- Parametrisation: p_nbits=8, MUL 0x0F*0x11 -> 0xFF after 9 cycles. With PROC_IMULDIV_EARLY_TERM_EN, MUL b=1 -> result after 2 cycles.
